ex_stage_md: RTL and testbench
==============================

# ex_stage_md

Parametrised execute stage for the RV32IM core. It replaces the purely combinational execute path with a registered stage. It provides N-way one-hot operand forwarding, ALU ops at single-cycle throughput, and an iterative RV32M multiply/divide unit that stalls the front end through a ready handshake. It also computes the full CSR write-data set: CSRRW/S/C and their immediate forms.

## Interface
- DWIDTH, 32: datapath width; even, at least 8.
- NUM_FWD, 2: number of forwarding sources; at least 1.

- clk  in  1  core clock
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  decode presents an op
- in_ready  out  1  stage can accept an op; high only in IDLE
- flush  in  1  abort the in-flight op (branch mispredict or trap)
- data_rs1, data_rs2  in  DWIDTH  register-file operands
- data_pc, data_imm  in  DWIDTH  PC and sign-extended immediate
- fwd_data  in  NUM_FWD*DWIDTH  forward values; channel k is at bits [k*DWIDTH +: DWIDTH]
- fwd_a_sel, fwd_b_sel  in  NUM_FWD  one-hot forward selects for rs1 and rs2
- ctrl_alu_func  in  4  ALU function code
- ctrl_alu_op  in  2  ALU op class
- ctrl_alu_src_a, ctrl_alu_src_b  in  2  operand-A and operand-B source selects; encodings as in the existing ALU datapath
- ctrl_md_en  in  1  op is RV32M
- ctrl_md_func  in  3  M-extension funct3
- ctrl_csr_we  in  1  op writes a CSR
- csr_func  in  3  CSR funct3
- csr_rdata  in  DWIDTH  current CSR value
- out_valid  out  1  one-cycle pulse: result registers valid
- ex_out  out  DWIDTH  ALU or M result
- csr_wdata  out  DWIDTH  CSR write value; 0 when ctrl_csr_we=0

## Operation

**Reset values**
- State is IDLE; out_valid=0; ex_out=0; csr_wdata=0.
- in_ready=1 in the first cycle after reset.

**Forwarding**
- The lowest set index in fwd_*_sel wins.
- All-zero select takes data_rs*.
- The forwarded rs1 value feeds both the ALU and the CSR path.

**Accept**
- An op is accepted when in_valid & in_ready & ~flush.

**Non-M op**
- The ALU result is registered into ex_out.
- csr_wdata is registered in the same cycle.
- State stays IDLE, so back-to-back ops are accepted.

**M op**
- Operands are latched and the FSM goes IDLE → BUSY.
- BUSY runs for exactly DWIDTH cycles:
  - multiply: radix-2 shift-add on magnitudes;
  - divide: restoring shift-subtract on magnitudes.
- BUSY → FIX for one cycle, which applies:
  - sign correction;
  - high/low result select;
  - special cases.
- FIX → IDLE, with the result registered and out_valid=1.
- Latency is constant for every M op, including the special cases.

**Multiply variants**
- MUL: low word of the product.
- MULH: signed × signed, high word.
- MULHSU: signed × unsigned, high word.
- MULHU: unsigned × unsigned, high word.
- Internal product width is 2*DWIDTH.

**Divide special cases (RISC-V rules)**
- Divide by zero: quotient all-ones; remainder = dividend.
- Signed overflow (most-negative / −1): quotient = dividend; remainder = 0.

**CSR write data**
- CSRRW: rs1.
- CSRRS: csr_rdata | rs1.
- CSRRC: csr_rdata & ~rs1.
- I-forms use zero-extended data_imm[4:0] in place of rs1.

**Flush**
- Synchronous; wins over in_valid.
- The FSM goes to IDLE next cycle and no out_valid is produced for the aborted op.
- A flush in cycle c forces out_valid=0 in cycle c+1.

**Reset mid-operation**
- Same effect as flush, and all result registers are also cleared.

## Timing
- Non-M op: accepted at edge 0; out_valid high in cycle 1.
- M op: accepted at edge 0; in_ready low in cycles 1..DWIDTH+1; out_valid and in_ready high in cycle DWIDTH+2.
- A new op may be accepted in the same cycle that out_valid pulses.
- ex_out and csr_wdata hold their value until the next result is written.
- in_ready is decoded combinationally from state only; there is no combinational path from in_valid.

## Structure
- Extend Opcode.vh with `FNC_MUL, `FNC_MULH, `FNC_MULHSU, `FNC_MULHU, `FNC_DIV, `FNC_DIVU, `FNC_REM, `FNC_REMU.
- New ExDefs.vh holds the FSM state encodings: IDLE, BUSY, FIX.
- Sub-module muldiv_iter holds the iterative datapath, counter, and FSM, with a start/flush/done interface.
- The top level keeps the forwarding muxes, the ALUCtrl/ALU instances, the CSR data logic, and the output registers.

## Test plan
- **Basic ALU:** ADD with rs1=5, rs2=7, then SUB 7−5 on the next cycle → ex_out=12 then 2, out_valid in consecutive cycles, in_ready always 1.
- **Forwarding priority:** fwd_a_sel=2'b11, channel 0=0x10, channel 1=0x20, rs1=0x99, ADD with imm 1 → ex_out=0x11. With sel=0 → ex_out=0x9A.
- **Multiply (DWIDTH=32):** results at cycle 34, in_ready low cycles 1..33.
  - MUL −3×7 → 0xFFFFFFEB.
  - MULH −1×−1 → 0x00000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU −1×2 → 0xFFFFFFFF.
- **Divide specials:**
  - DIV 0x80000000/−1 → 0x80000000; REM of the same → 0.
  - DIVU 7/0 → 0xFFFFFFFF; REMU 7/0 → 7.
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
- **Flush during divide:** flush in cycle 10 of a DIV → no out_valid, in_ready=1 in cycle 11. ADD 1+1 accepted in cycle 11 → ex_out=2 in cycle 12.
- **CSR write data:**
  - CSRRS with csr_rdata=0xF0, rs1=0x0F → csr_wdata=0xFF.
  - CSRRCI with imm=3, csr_rdata=7 → 4.
  - ctrl_csr_we=0 → 0.

Source files
------------

// File: rtl/ex_stage_md_pkg.sv
// Shared encodings for the registered execute stage: FSM states, RV32M funct3,
// ALU control classes/operand sources and CSR funct3 low bits.
package ex_stage_md_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    localparam logic [2:0] FNC_MUL    = 3'd0;
    localparam logic [2:0] FNC_MULH   = 3'd1;
    localparam logic [2:0] FNC_MULHSU = 3'd2;
    localparam logic [2:0] FNC_MULHU  = 3'd3;
    localparam logic [2:0] FNC_DIV    = 3'd4;
    localparam logic [2:0] FNC_DIVU   = 3'd5;
    localparam logic [2:0] FNC_REM    = 3'd6;
    localparam logic [2:0] FNC_REMU   = 3'd7;

    localparam logic [1:0] ALU_OP_ADD = 2'd0;
    localparam logic [1:0] ALU_OP_R   = 2'd1;
    localparam logic [1:0] ALU_OP_I   = 2'd2;
    localparam logic [1:0] ALU_OP_LUI = 2'd3;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [1:0] CSR_RW = 2'd1;
    localparam logic [1:0] CSR_RS = 2'd2;
    localparam logic [1:0] CSR_RC = 3'd3;

    function automatic logic md_a_signed(input logic [2:0] f);
        return (f == FNC_MUL) || (f == FNC_MULH) || (f == FNC_MULHSU) ||
               (f == FNC_DIV) || (f == FNC_REM);
    endfunction

    function automatic logic md_b_signed(input logic [2:0] f);
        return (f == FNC_MUL) || (f == FNC_MULH) || (f == FNC_DIV) || (f == FNC_REM);
    endfunction

endpackage

// File: rtl/ex_stage_md_muldiv_iter.sv
// Iterative RV32M unit: DWIDTH shift-add / restoring shift-subtract steps on
// magnitudes, then one FIX cycle for sign, word select and divide special cases.
module muldiv_iter
    import ex_stage_md_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [2:0]        func_i,
    input  logic [DWIDTH-1:0] a_i,
    input  logic [DWIDTH-1:0] b_i,
    output logic              idle_o,
    output logic              done_o,
    output logic [DWIDTH-1:0] result_o
);
    localparam int unsigned CW = $clog2(DWIDTH);
    localparam logic [DWIDTH-1:0] MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

    md_state_e         state_q;
    logic [CW-1:0]     cnt_q;
    logic [DWIDTH-1:0] hi_q, lo_q, b_q, a_raw_q;
    logic [2:0]        func_q;
    logic              neg_q, neg_a_q, div0_q, ovf_q;

    logic              a_neg, b_neg, ge;
    logic [DWIDTH-1:0] a_mag, b_mag, quo, rem;
    logic [DWIDTH:0]   msum, rsh, rdiff;
    logic [2*DWIDTH-1:0] prod;

    always_comb begin
        a_neg = md_a_signed(func_i) & a_i[DWIDTH-1];
        b_neg = md_b_signed(func_i) & b_i[DWIDTH-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;
        // multiply step: add multiplicand when multiplier LSB set, then shift {hi,lo} right
        msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        // divide step: shift next dividend bit into the partial remainder
        rsh   = {hi_q, lo_q[DWIDTH-1]};
        rdiff = rsh - {1'b0, b_q};
        ge    = (rsh >= {1'b0, b_q});
    end

    always_comb begin
        prod = {hi_q, lo_q};
        if (neg_q) prod = -prod;
        quo = neg_q ? -lo_q : lo_q;
        rem = neg_a_q ? -hi_q : hi_q;
        unique case (func_q)
            FNC_MUL:                       result_o = prod[DWIDTH-1:0];
            FNC_MULH, FNC_MULHSU, FNC_MULHU: result_o = prod[2*DWIDTH-1:DWIDTH];
            FNC_DIV, FNC_DIVU:             result_o = div0_q ? '1 : (ovf_q ? a_raw_q : quo);
            default:                       result_o = div0_q ? a_raw_q : (ovf_q ? '0 : rem);
        endcase
    end

    assign idle_o = (state_q == ST_IDLE);
    assign done_o = (state_q == ST_FIX) & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            a_raw_q <= '0;
            func_q  <= '0;
            neg_q   <= 1'b0;
            neg_a_q <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (start_i) begin
                    state_q <= ST_BUSY;
                    cnt_q   <= '0;
                    hi_q    <= '0;
                    lo_q    <= a_mag;
                    b_q     <= b_mag;
                    a_raw_q <= a_i;
                    func_q  <= func_i;
                    neg_q   <= a_neg ^ b_neg;
                    neg_a_q <= a_neg;
                    div0_q  <= func_i[2] & (b_i == '0);
                    ovf_q   <= func_i[2] & ~func_i[0] & (a_i == MOST_NEG) & (b_i == '1);
                end
                ST_BUSY: begin
                    if (func_q[2]) begin
                        hi_q <= ge ? rdiff[DWIDTH-1:0] : rsh[DWIDTH-1:0];
                        lo_q <= {lo_q[DWIDTH-2:0], ge};
                    end else begin
                        hi_q <= msum[DWIDTH:1];
                        lo_q <= {msum[0], lo_q[DWIDTH-1:1]};
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DWIDTH-1)) state_q <= ST_FIX;
                end
                ST_FIX:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage_md.sv
// Registered execute stage: one-hot operand forwarding, single-cycle ALU,
// CSR write-data generation and an iterative RV32M unit behind in_ready.
module ex_stage_md
    import ex_stage_md_pkg::*;
#(
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned NUM_FWD = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    input  logic [DWIDTH-1:0]         data_rs1,
    input  logic [DWIDTH-1:0]         data_rs2,
    input  logic [DWIDTH-1:0]         data_pc,
    input  logic [DWIDTH-1:0]         data_imm,
    input  logic [NUM_FWD*DWIDTH-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_a_sel,
    input  logic [NUM_FWD-1:0]        fwd_b_sel,
    input  logic [3:0]                ctrl_alu_func,
    input  logic [1:0]                ctrl_alu_op,
    input  logic [1:0]                ctrl_alu_src_a,
    input  logic [1:0]                ctrl_alu_src_b,
    input  logic                      ctrl_md_en,
    input  logic [2:0]                ctrl_md_func,
    input  logic                      ctrl_csr_we,
    input  logic [2:0]                csr_func,
    input  logic [DWIDTH-1:0]         csr_rdata,
    output logic                      out_valid,
    output logic [DWIDTH-1:0]         ex_out,
    output logic [DWIDTH-1:0]         csr_wdata
);
    localparam int unsigned SHW = $clog2(DWIDTH);

    logic [DWIDTH-1:0] rs1_fwd, rs2_fwd, op_a, op_b, alu_res, csr_src, csr_val, md_result;
    logic [SHW-1:0]    shamt;
    logic              accept, md_idle, md_done;
    logic              out_valid_q, out_valid_d;
    logic [DWIDTH-1:0] ex_out_q, ex_out_d, csr_wdata_q, csr_wdata_d;

    // walk channels high to low so the lowest set select is written last and wins
    always_comb begin
        rs1_fwd = data_rs1;
        rs2_fwd = data_rs2;
        for (int unsigned k = 0; k < NUM_FWD; k++) begin
            if (fwd_a_sel[NUM_FWD-1-k]) rs1_fwd = fwd_data[(NUM_FWD-1-k)*DWIDTH +: DWIDTH];
            if (fwd_b_sel[NUM_FWD-1-k]) rs2_fwd = fwd_data[(NUM_FWD-1-k)*DWIDTH +: DWIDTH];
        end
    end

    always_comb begin
        unique case (ctrl_alu_src_a)
            SRC_A_RS1: op_a = rs1_fwd;
            SRC_A_PC:  op_a = data_pc;
            default:   op_a = '0;
        endcase
        unique case (ctrl_alu_src_b)
            SRC_B_RS2:  op_b = rs2_fwd;
            SRC_B_IMM:  op_b = data_imm;
            SRC_B_FOUR: op_b = DWIDTH'(4);
            default:    op_b = '0;
        endcase
        shamt = op_b[SHW-1:0];
        if (ctrl_alu_op == ALU_OP_ADD) begin
            alu_res = op_a + op_b;
        end else if (ctrl_alu_op == ALU_OP_LUI) begin
            alu_res = op_b;
        end else begin
            unique case (ctrl_alu_func[2:0])
                // funct7[5] selects SUB only for register-register ops
                F3_ADD:  alu_res = (ctrl_alu_op == ALU_OP_R && ctrl_alu_func[3]) ? op_a - op_b : op_a + op_b;
                F3_SLL:  alu_res = op_a << shamt;
                F3_SLT:  alu_res = {{(DWIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                F3_SLTU: alu_res = {{(DWIDTH-1){1'b0}}, op_a < op_b};
                F3_XOR:  alu_res = op_a ^ op_b;
                F3_SR:   alu_res = ctrl_alu_func[3] ? DWIDTH'($signed(op_a) >>> shamt) : op_a >> shamt;
                F3_OR:   alu_res = op_a | op_b;
                default: alu_res = op_a & op_b;
            endcase
        end
    end

    always_comb begin
        csr_src = csr_func[2] ? {{(DWIDTH-5){1'b0}}, data_imm[4:0]} : rs1_fwd;
        unique case (csr_func[1:0])
            CSR_RW:  csr_val = csr_src;
            CSR_RS:  csr_val = csr_rdata | csr_src;
            CSR_RC:  csr_val = csr_rdata & ~csr_src;
            default: csr_val = '0;
        endcase
        if (!ctrl_csr_we) csr_val = '0;
    end

    assign in_ready = md_idle;
    assign accept   = in_valid & in_ready & ~flush;

    muldiv_iter #(.DWIDTH(DWIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (accept & ctrl_md_en),
        .flush_i  (flush),
        .func_i   (ctrl_md_func),
        .a_i      (rs1_fwd),
        .b_i      (rs2_fwd),
        .idle_o   (md_idle),
        .done_o   (md_done),
        .result_o (md_result)
    );

    always_comb begin
        out_valid_d = 1'b0;
        ex_out_d    = ex_out_q;
        csr_wdata_d = csr_wdata_q;
        if (accept && !ctrl_md_en) begin
            out_valid_d = 1'b1;
            ex_out_d    = alu_res;
            csr_wdata_d = csr_val;
        end else if (md_done) begin
            out_valid_d = 1'b1;
            ex_out_d    = md_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ex_out_q    <= '0;
            csr_wdata_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ex_out_q    <= ex_out_d;
            csr_wdata_q <= csr_wdata_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ex_out    = ex_out_q;
    assign csr_wdata = csr_wdata_q;

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md: vector table for ALU/CSR/M results and latency,
// plus hand-written sequences for back-to-back issue, flush and mid-op reset.
module tb_ex_stage_md;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, flush;
    logic [DW-1:0] data_rs1, data_rs2, data_pc, data_imm, csr_rdata;
    logic [2*DW-1:0] fwd_data;
    logic [1:0]    fwd_a_sel, fwd_b_sel, ctrl_alu_op, ctrl_alu_src_a, ctrl_alu_src_b;
    logic [3:0]    ctrl_alu_func;
    logic          ctrl_md_en, ctrl_csr_we, out_valid;
    logic [2:0]    ctrl_md_func, csr_func;
    logic [DW-1:0] ex_out, csr_wdata;

    int n_cmp = 0;
    int n_err = 0;

    ex_stage_md #(.DWIDTH(DW), .NUM_FWD(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .data_rs1(data_rs1), .data_rs2(data_rs2), .data_pc(data_pc), .data_imm(data_imm),
        .fwd_data(fwd_data), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .ctrl_alu_func(ctrl_alu_func), .ctrl_alu_op(ctrl_alu_op),
        .ctrl_alu_src_a(ctrl_alu_src_a), .ctrl_alu_src_b(ctrl_alu_src_b),
        .ctrl_md_en(ctrl_md_en), .ctrl_md_func(ctrl_md_func),
        .ctrl_csr_we(ctrl_csr_we), .csr_func(csr_func), .csr_rdata(csr_rdata),
        .out_valid(out_valid), .ex_out(ex_out), .csr_wdata(csr_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        md;
        logic [1:0]  aop;
        logic [3:0]  fn;
        logic [1:0]  sa, sb, fa, fb;
        logic [31:0] rs1, rs2, imm, crd;
        logic        cwe;
        logic [2:0]  cf;
        logic [31:0] exp_ex, exp_csr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v_alu(input string n, input logic [1:0] aop, input logic [3:0] fn,
                                   input logic [1:0] sa, input logic [1:0] sb,
                                   input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                                   input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] e);
        vec_t v;
        v.name = n; v.md = 1'b0; v.aop = aop; v.fn = fn; v.sa = sa; v.sb = sb;
        v.fa = fa; v.fb = fb; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.crd = 32'h0;
        v.cwe = 1'b0; v.cf = 3'd1; v.exp_ex = e; v.exp_csr = 32'h0;
        return v;
    endfunction

    function automatic vec_t v_csr(input string n, input logic [2:0] cf, input logic [31:0] rs1,
                                   input logic [31:0] imm, input logic [31:0] crd, input logic cwe,
                                   input logic [1:0] fa, input logic [31:0] e_ex, input logic [31:0] e_csr);
        vec_t v;
        v = v_alu(n, 2'd0, 4'd0, 2'd0, 2'd1, rs1, 32'h0, imm, fa, 2'b00, e_ex);
        v.cf = cf; v.crd = crd; v.cwe = cwe; v.exp_csr = e_csr;
        return v;
    endfunction

    function automatic vec_t v_md(input string n, input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] e);
        vec_t v;
        v = v_alu(n, 2'd1, {1'b0, f}, 2'd0, 2'd0, a, b, 32'h0, 2'b00, 2'b00, e);
        v.md = 1'b1;
        return v;
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        data_rs1 = v.rs1; data_rs2 = v.rs2; data_imm = v.imm; data_pc = 32'h1000;
        fwd_data = {32'h20, 32'h10}; fwd_a_sel = v.fa; fwd_b_sel = v.fb;
        ctrl_alu_op = v.aop; ctrl_alu_func = v.fn; ctrl_alu_src_a = v.sa; ctrl_alu_src_b = v.sb;
        ctrl_md_en = v.md; ctrl_md_func = v.fn[2:0];
        ctrl_csr_we = v.cwe; csr_func = v.cf; csr_rdata = v.crd;
    endtask

    task automatic wait_result(output int cyc, output int rdy_hi);
        cyc = 1; rdy_hi = 0;
        while (!out_valid && cyc < 60) begin
            if (in_ready) rdy_hi++;
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc, rdy_hi;
        @(negedge clk); drive(v); in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        wait_result(cyc, rdy_hi);
        check({v.name, ":latency"}, cyc, v.md ? 34 : 1);
        check({v.name, ":busy_ready_hi"}, rdy_hi, 0);
        check({v.name, ":in_ready"}, {31'b0, in_ready}, 1);
        check({v.name, ":ex_out"}, ex_out, v.exp_ex);
        if (!v.md) check({v.name, ":csr_wdata"}, csr_wdata, v.exp_csr);
    endtask

    task automatic count_pulses(input string n, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check(n, pulses, 0);
    endtask

    initial begin
        int cyc, rdy_hi;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        drive(v_alu("idle", 2'd0, 4'd0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0));
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        check("reset:out_valid", {31'b0, out_valid}, 0);
        check("reset:ex_out", ex_out, 0);
        check("reset:csr_wdata", csr_wdata, 0);
        check("reset:in_ready", {31'b0, in_ready}, 1);

        vecs.push_back(v_alu("fwd_a_lowest", 2'd2, 4'd0, 2'd0, 2'd1, 32'h99, 32'h0, 32'h1, 2'b11, 2'b00, 32'h11));
        vecs.push_back(v_alu("fwd_a_none", 2'd2, 4'd0, 2'd0, 2'd1, 32'h99, 32'h0, 32'h1, 2'b00, 2'b00, 32'h9A));
        vecs.push_back(v_alu("fwd_a_ch1", 2'd2, 4'd0, 2'd0, 2'd1, 32'h99, 32'h0, 32'h1, 2'b10, 2'b00, 32'h21));
        vecs.push_back(v_alu("fwd_b_ch0", 2'd1, 4'd0, 2'd0, 2'd0, 32'h1, 32'h77, 32'h0, 2'b00, 2'b01, 32'h11));
        vecs.push_back(v_alu("sub_neg", 2'd1, 4'd8, 2'd0, 2'd0, 32'h3, 32'h5, 32'h0, 2'b00, 2'b00, 32'hFFFFFFFE));
        vecs.push_back(v_alu("slt", 2'd1, 4'd2, 2'd0, 2'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 2'b00, 2'b00, 32'h1));
        vecs.push_back(v_alu("sltu", 2'd1, 4'd3, 2'd0, 2'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 2'b00, 2'b00, 32'h0));
        vecs.push_back(v_alu("sra", 2'd1, 4'd13, 2'd0, 2'd0, 32'h80000000, 32'h4, 32'h0, 2'b00, 2'b00, 32'hF8000000));
        vecs.push_back(v_alu("srl", 2'd1, 4'd5, 2'd0, 2'd0, 32'h80000000, 32'h4, 32'h0, 2'b00, 2'b00, 32'h08000000));
        vecs.push_back(v_alu("slli", 2'd2, 4'd1, 2'd0, 2'd1, 32'h1, 32'h0, 32'd31, 2'b00, 2'b00, 32'h80000000));
        vecs.push_back(v_alu("xori", 2'd2, 4'd4, 2'd0, 2'd1, 32'hF0F0, 32'h0, 32'hFF, 2'b00, 2'b00, 32'hF00F));
        vecs.push_back(v_alu("and", 2'd1, 4'd7, 2'd0, 2'd0, 32'hFF00, 32'h0FF0, 32'h0, 2'b00, 2'b00, 32'h0F00));
        vecs.push_back(v_alu("or", 2'd1, 4'd6, 2'd0, 2'd0, 32'hFF00, 32'h0FF0, 32'h0, 2'b00, 2'b00, 32'hFFF0));
        vecs.push_back(v_alu("addi_bit3", 2'd2, 4'd8, 2'd0, 2'd1, 32'd10, 32'h0, 32'd3, 2'b00, 2'b00, 32'd13));
        vecs.push_back(v_alu("auipc", 2'd0, 4'd0, 2'd1, 2'd1, 32'h0, 32'h0, 32'h2000, 2'b00, 2'b00, 32'h3000));
        vecs.push_back(v_alu("link_pc4", 2'd0, 4'd0, 2'd1, 2'd2, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h1004));
        vecs.push_back(v_alu("lui", 2'd3, 4'd0, 2'd0, 2'd1, 32'h5, 32'h0, 32'hABCDE000, 2'b00, 2'b00, 32'hABCDE000));
        vecs.push_back(v_csr("csrrs", 3'd2, 32'h0F, 32'h0, 32'hF0, 1'b1, 2'b00, 32'h0F, 32'hFF));
        vecs.push_back(v_csr("csrrci", 3'd7, 32'h55, 32'h3, 32'h7, 1'b1, 2'b00, 32'h58, 32'h4));
        vecs.push_back(v_csr("csr_we0", 3'd1, 32'h55, 32'h0, 32'h7, 1'b0, 2'b00, 32'h55, 32'h0));
        vecs.push_back(v_csr("csrrw_fwd", 3'd1, 32'h55, 32'h0, 32'h7, 1'b1, 2'b01, 32'h10, 32'h10));
        vecs.push_back(v_csr("csrrc", 3'd3, 32'h0F, 32'h0, 32'hFF, 1'b1, 2'b00, 32'h0F, 32'hF0));
        vecs.push_back(v_csr("csrrsi_zext", 3'd6, 32'h0, 32'h25, 32'h100, 1'b1, 2'b00, 32'h25, 32'h105));
        vecs.push_back(v_md("mul_neg", 3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB));
        vecs.push_back(v_md("mul_lo", 3'd0, 32'h12345678, 32'h10, 32'h23456780));
        vecs.push_back(v_md("mulh_m1m1", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0));
        vecs.push_back(v_md("mulh_max", 3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF));
        vecs.push_back(v_md("mulhu_max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE));
        vecs.push_back(v_md("mulhsu_m1x2", 3'd2, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF));
        vecs.push_back(v_md("mulhsu_min", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000));
        vecs.push_back(v_md("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000));
        vecs.push_back(v_md("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0));
        vecs.push_back(v_md("divu_by0", 3'd5, 32'd7, 32'h0, 32'hFFFFFFFF));
        vecs.push_back(v_md("remu_by0", 3'd7, 32'd7, 32'h0, 32'd7));
        vecs.push_back(v_md("div_by0_neg", 3'd4, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFF));
        vecs.push_back(v_md("rem_by0_neg", 3'd6, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB));
        vecs.push_back(v_md("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD));
        vecs.push_back(v_md("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF));
        vecs.push_back(v_md("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14));
        vecs.push_back(v_md("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2));
        vecs.push_back(v_md("divu_big", 3'd5, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF));

        foreach (vecs[i]) run_vec(vecs[i]);

        // back-to-back ALU ops
        @(negedge clk);
        drive(v_alu("add", 2'd1, 4'd0, 2'd0, 2'd0, 32'd5, 32'd7, 32'h0, 2'b00, 2'b00, 32'd12));
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b:valid1", {31'b0, out_valid}, 1);
        check("b2b:ex1", ex_out, 32'd12);
        check("b2b:ready1", {31'b0, in_ready}, 1);
        drive(v_alu("sub", 2'd1, 4'd8, 2'd0, 2'd0, 32'd7, 32'd5, 32'h0, 2'b00, 2'b00, 32'd2));
        @(posedge clk); #1; in_valid = 1'b0;
        check("b2b:valid2", {31'b0, out_valid}, 1);
        check("b2b:ex2", ex_out, 32'd2);
        @(posedge clk); #1;
        check("b2b:valid_drop", {31'b0, out_valid}, 0);

        // accept a new op in the cycle the M result pulses
        @(negedge clk); drive(v_md("mul", 3'd0, 32'd3, 32'd5, 32'd15)); in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        wait_result(cyc, rdy_hi);
        check("mul_then_add:latency", cyc, 34);
        check("mul_then_add:mul", ex_out, 32'd15);
        drive(v_alu("add", 2'd1, 4'd0, 2'd0, 2'd0, 32'd1, 32'd2, 32'h0, 2'b00, 2'b00, 32'd3));
        in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        check("mul_then_add:valid", {31'b0, out_valid}, 1);
        check("mul_then_add:add", ex_out, 32'd3);

        // flush wins over in_valid
        @(negedge clk);
        drive(v_alu("add", 2'd1, 4'd0, 2'd0, 2'd0, 32'd4, 32'd4, 32'h0, 2'b00, 2'b00, 32'd8));
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
        check("flush_valid:out_valid", {31'b0, out_valid}, 0);
        check("flush_valid:ex_hold", ex_out, 32'd3);

        // flush in cycle 10 of a divide
        @(negedge clk); drive(v_md("div", 3'd4, 32'd100, 32'd7, 32'd14)); in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("flush_div:busy", {31'b0, in_ready}, 0);
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_div:ready", {31'b0, in_ready}, 1);
        check("flush_div:no_valid", {31'b0, out_valid}, 0);
        drive(v_alu("add", 2'd1, 4'd0, 2'd0, 2'd0, 32'd1, 32'd1, 32'h0, 2'b00, 2'b00, 32'd2));
        in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        check("flush_div:add_valid", {31'b0, out_valid}, 1);
        check("flush_div:add_ex", ex_out, 32'd2);
        count_pulses("flush_div:stray_valid", 40);

        // flush in the FIX cycle suppresses the result
        @(negedge clk); drive(v_md("divu", 3'd5, 32'd100, 32'd7, 32'd14)); in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (32) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_fix:no_valid", {31'b0, out_valid}, 0);
        check("flush_fix:ready", {31'b0, in_ready}, 1);
        check("flush_fix:ex_hold", ex_out, 32'd2);

        // reset mid-multiply clears results
        run_vec(v_csr("csrrs_pre_rst", 3'd2, 32'h0F, 32'h0, 32'hF0, 1'b1, 2'b00, 32'h0F, 32'hFF));
        @(negedge clk); drive(v_md("mul", 3'd0, 32'd9, 32'd9, 32'd81)); in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check("rst_mid:ex_out", ex_out, 32'h0);
        check("rst_mid:csr_wdata", csr_wdata, 32'h0);
        check("rst_mid:out_valid", {31'b0, out_valid}, 0);
        check("rst_mid:in_ready", {31'b0, in_ready}, 1);
        count_pulses("rst_mid:stray_valid", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
